// File: rtl/decoder_3to8_if.sv
// Bus bundle for the registered 3-to-8 decoder: request side (en/add)
// and decoded result side (dout/dout_vld).
interface decoder_3to8_if;
    logic       en;
    logic [2:0] add;
    logic [7:0] dout;
    logic       dout_vld;

    // Requester drives enable/address and observes the select word.
    modport master (
        output en,
        output add,
        input  dout,
        input  dout_vld
    );

    // Decoder consumes enable/address and produces the select word.
    modport slave (
        input  en,
        input  add,
        output dout,
        output dout_vld
    );
endinterface

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder with enable, used as a chip-select or
// row-select generator. Output polarity and registering are parameters.
module decoder_3to8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0,
    parameter bit REG_OUT        = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    decoder_3to8_if.slave bus
);

    // XOR mask that turns the raw one-hot word into the output polarity;
    // it is also the all-inactive value used for reset and disable.
    localparam logic [7:0] PolMask = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] raw_d;
    logic [7:0] dout_d;
    logic       vld_d;

    // Decode: one-hot when enabled, all-zero otherwise, then apply polarity.
    always_comb begin
        raw_d = 8'h00;
        if (bus.en) begin
            raw_d = 8'h01 << bus.add;
        end
        dout_d = raw_d ^ PolMask;
        vld_d  = bus.en;
    end

    if (REG_OUT) begin : g_reg
        logic [7:0] dout_q;
        logic       vld_q;

        // Capture the decode each edge; reset forces the inactive word at once.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= PolMask;
                vld_q  <= 1'b0;
            end else begin
                dout_q <= dout_d;
                vld_q  <= vld_d;
            end
        end

        assign bus.dout     = dout_q;
        assign bus.dout_vld = vld_q;
    end else begin : g_comb
        // Pure combinational path; clock and reset are intentionally unused.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign bus.dout     = dout_d;
        assign bus.dout_vld = vld_d;
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: default, active-low and combinational
// instances share stimulus and are checked against a hand-written table.
module tb_decoder_3to8;

    typedef struct packed {
        logic       en;
        logic [2:0] add;
        logic [7:0] exp_dout;
        logic       exp_vld;
    } vec_t;

    localparam int NumVecs = 21;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [2:0] add = 3'd0;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_3to8_if bus_a ();
    decoder_3to8_if bus_l ();
    decoder_3to8_if bus_c ();

    assign bus_a.en  = en;
    assign bus_a.add = add;
    assign bus_l.en  = en;
    assign bus_l.add = add;
    assign bus_c.en  = en;
    assign bus_c.add = add;

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) u_dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l.slave)
    );

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) u_dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c.slave)
    );

    always #5 clk = ~clk;

    vec_t vecs [NumVecs] = '{
        // disabled, add ignored
        '{1'b0, 3'd7, 8'h00, 1'b0},
        '{1'b0, 3'd7, 8'h00, 1'b0},
        // ascending sweep
        '{1'b1, 3'd0, 8'h01, 1'b1},
        '{1'b1, 3'd1, 8'h02, 1'b1},
        '{1'b1, 3'd2, 8'h04, 1'b1},
        '{1'b1, 3'd3, 8'h08, 1'b1},
        '{1'b1, 3'd4, 8'h10, 1'b1},
        '{1'b1, 3'd5, 8'h20, 1'b1},
        '{1'b1, 3'd6, 8'h40, 1'b1},
        '{1'b1, 3'd7, 8'h80, 1'b1},
        // descending sweep
        '{1'b1, 3'd7, 8'h80, 1'b1},
        '{1'b1, 3'd6, 8'h40, 1'b1},
        '{1'b1, 3'd5, 8'h20, 1'b1},
        '{1'b1, 3'd4, 8'h10, 1'b1},
        '{1'b1, 3'd3, 8'h08, 1'b1},
        '{1'b1, 3'd2, 8'h04, 1'b1},
        '{1'b1, 3'd1, 8'h02, 1'b1},
        '{1'b1, 3'd0, 8'h01, 1'b1},
        // enable drop and restore at add=5
        '{1'b1, 3'd5, 8'h20, 1'b1},
        '{1'b0, 3'd5, 8'h00, 1'b0},
        '{1'b1, 3'd5, 8'h20, 1'b1}
    };

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Registered instances after an edge: default and active-low.
    task automatic chk_reg(input string tag, input logic [7:0] exp_d, input logic exp_v);
        chk({tag, " dout"}, bus_a.dout, exp_d);
        chk({tag, " vld"}, {7'd0, bus_a.dout_vld}, {7'd0, exp_v});
        chk({tag, " dout_lo"}, bus_l.dout, ~exp_d);
        chk({tag, " vld_lo"}, {7'd0, bus_l.dout_vld}, {7'd0, exp_v});
    endtask

    task automatic chk_comb(input string tag, input logic [7:0] exp_d, input logic exp_v);
        chk({tag, " dout_comb"}, bus_c.dout, exp_d);
        chk({tag, " vld_comb"}, {7'd0, bus_c.dout_vld}, {7'd0, exp_v});
    endtask

    initial begin
        // Reset before any clock edge, with en=1 add=3 presented.
        en  = 1'b1;
        add = 3'd3;
        #1 rst_n = 1'b0;
        #1;
        chk_reg("reset_immediate", 8'h00, 1'b0);
        chk_comb("reset_ignored", 8'h08, 1'b1);
        @(posedge clk); #1;
        chk_reg("reset_hold1", 8'h00, 1'b0);
        @(posedge clk); #1;
        chk_reg("reset_hold2", 8'h00, 1'b0);
        // Release between edges; nothing decodes until the next rising edge.
        #2 rst_n = 1'b1;
        #1;
        chk_reg("release_no_edge", 8'h00, 1'b0);
        @(posedge clk); #1;
        chk_reg("first_decode", 8'h08, 1'b1);

        // Table: apply, check comb path immediately, registered one edge later.
        for (int i = 0; i < NumVecs; i++) begin
            en  = vecs[i].en;
            add = vecs[i].add;
            #1;
            chk_comb($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_vld);
            @(posedge clk); #1;
            chk_reg($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_vld);
        end

        // Outputs hold between edges when add changes mid-cycle.
        add = 3'd1;
        #2;
        chk_reg("hold_mid_cycle", 8'h20, 1'b1);
        chk_comb("comb_follows", 8'h02, 1'b1);
        @(posedge clk); #1;
        chk_reg("after_hold", 8'h02, 1'b1);

        // Async reset pulse between edges clears immediately.
        add = 3'd5;
        @(posedge clk); #1;
        chk_reg("pre_pulse", 8'h20, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_reg("pulse_clear", 8'h00, 1'b0);
        chk_comb("pulse_comb", 8'h20, 1'b1);
        #1 rst_n = 1'b1;
        #1;
        chk_reg("pulse_no_retain", 8'h00, 1'b0);
        @(posedge clk); #1;
        chk_reg("pulse_redecode", 8'h20, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
